// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, polarity constants and width helper for the VGA scan-out engine
//
// Default timing is 640x480@60 (25.175 MHz pixel clock). H_TOTAL_DEF / V_TOTAL_DEF
// are the derived line and frame lengths for that mode.

package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_axis_cntr.sv
// rtl/vga_axis_cntr.sv - generic single-axis scan counter (active, front porch, sync, back porch)
//
// Ports:
//   clock   in   pixel clock
//   nreset  in   asynchronous active-low reset, count returns to 0
//   adv     in   advance enable; count moves by one when high
//   count   out  current position 0..TOTAL-1
//   active  out  count is inside the visible region
//   sync    out  count is inside the sync region (polarity-free, 1 = in sync)
//   last    out  count is TOTAL-1; the next advance wraps to 0

module vga_axis_cntr
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int CNT_W  = width_of(ACTIVE + FP + SYNC + BP)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             active,
    output logic             sync,
    output logic             last
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_FIRST  = CNT_W'(ACTIVE + FP);
    // Inclusive upper bound so a zero back porch cannot overflow CNT_W.
    localparam logic [CNT_W-1:0] SYNC_FINAL  = CNT_W'(ACTIVE + FP + SYNC - 1);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (adv) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    assign last   = (count == LAST_C);
    assign active = (count < ACTIVE_C);
    assign sync   = (count >= SYNC_FIRST) && (count <= SYNC_FINAL);

endmodule

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA scan-out engine: sync/de generation, scaled framebuffer fetch, latency-matched outputs
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode input, 8 vertical colour bars).
//
// Ports:
//   clock             in   pixel clock
//   nreset            in   asynchronous active-low reset
//   pixel_data        in   framebuffer read data; must be valid RD_LAT clocks after the counter
//                          position that produced pixel_addr (pixel_addr's own register is the first)
//   fb_base           in   base address of next frame, sampled on the last clock of each frame
//   test_mode         in   (VGA_TEST_PATTERN_EN only) show colour bars instead of pixel_data
//   pixel_addr        out  registered framebuffer read address
//   pixel             out  registered colour, 0 outside the active area
//   h_sync            out  horizontal sync, active level SYNC_POL
//   v_sync            out  vertical sync, active level SYNC_POL
//   de                out  display enable, aligned with pixel
//   v_blank_interupt  out  active-low one-clock pulse when counters reach (h=0, v=V_ACTIVE)

module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SCALE    = 2,
    parameter int PIX_W    = 12,
    parameter int ADDR_W   = 17,
    parameter int RD_LAT   = 1,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [PIX_W-1:0]  pixel_data,
    input  logic [ADDR_W-1:0] fb_base,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel,
    output logic              h_sync,
    output logic              v_sync,
    output logic              de,
    output logic              v_blank_interupt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = width_of(H_TOTAL);
    localparam int V_W     = width_of(V_TOTAL);
    localparam int DEPTH   = 1 + RD_LAT;
    localparam int SUB_W   = width_of(SCALE);

    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_ACTIVE / SCALE);
    localparam logic [H_W-1:0]    H_LAST_ACT = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0]    V_LAST_ACT = V_W'(V_ACTIVE - 1);

    // ------------------------------------------------------------------
    // Stage 0: scan counters
    // ------------------------------------------------------------------
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_active, h_in_sync, h_last;
    logic           v_active, v_in_sync, v_last;
    logic           disp;
    logic           frame_end;

    vga_axis_cntr #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (H_W)
    ) u_h_cntr (
        .clock  (clock),
        .nreset (nreset),
        .adv    (1'b1),
        .count  (h_cnt),
        .active (h_active),
        .sync   (h_in_sync),
        .last   (h_last)
    );

    vga_axis_cntr #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (V_W)
    ) u_v_cntr (
        .clock  (clock),
        .nreset (nreset),
        .adv    (h_last),
        .count  (v_cnt),
        .active (v_active),
        .sync   (v_in_sync),
        .last   (v_last)
    );

    assign disp      = h_active && v_active;
    assign frame_end = h_last && v_last;

    // ------------------------------------------------------------------
    // Address generation (incremental, no multiplier)
    // line_start doubles as the per-frame latched base: it is loaded from
    // fb_base on the last clock of the frame and only advanced by ROW_STEP
    // after SCALE repeats of a source row.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] line_start;
    logic [SUB_W-1:0]  col_sub;
    logic [SUB_W-1:0]  row_sub;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pixel_addr <= '0;
            line_start <= '0;
            col_sub    <= '0;
            row_sub    <= '0;
        end else begin
            if (frame_end) begin
                line_start <= fb_base;
                row_sub    <= '0;
            end else if (disp && (h_cnt == H_LAST_ACT)) begin
                if (row_sub == SUB_LAST) begin
                    row_sub    <= '0;
                    line_start <= line_start + ROW_STEP;
                end else begin
                    row_sub <= row_sub + 1'b1;
                end
            end

            // Outside the active area the address simply holds.
            if (disp) begin
                if (h_cnt == '0) begin
                    pixel_addr <= line_start;
                    col_sub    <= '0;
                end else if (col_sub == SUB_LAST) begin
                    pixel_addr <= pixel_addr + 1'b1;
                    col_sub    <= '0;
                end else begin
                    col_sub <= col_sub + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Timing delay lines: bit k holds the stage-(k+1) copy, so the top bit
    // lines up with pixel, which is loaded from stage DEPTH-1.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] de_q;
    logic [DEPTH-1:0] hs_q;
    logic [DEPTH-1:0] vs_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            de_q <= '0;
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            de_q <= {de_q[DEPTH-2:0], disp};
            hs_q <= {hs_q[DEPTH-2:0], h_in_sync};
            vs_q <= {vs_q[DEPTH-2:0], v_in_sync};
        end
    end

    // ------------------------------------------------------------------
    // Pixel source
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] src_pix;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_LEN = H_ACTIVE / 8;
    localparam int BAR_W   = width_of(BAR_LEN);
    localparam int CW      = PIX_W / 3;

    localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_LEN - 1);

    logic [BAR_W-1:0] bar_cnt;
    logic [2:0]       bar_idx;
    logic [PIX_W-1:0] bar_rgb;
    logic [PIX_W-1:0] bar_q [RD_LAT];

    // bar_idx tracks h_cnt / BAR_LEN without a divider.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (h_last) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (h_active) begin
            if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    assign bar_rgb = PIX_W'({{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}});

    // Bar colour follows the same stage timing as the fetched data.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                bar_q[i] <= '0;
            end
        end else begin
            bar_q[0] <= bar_rgb;
            for (int i = 1; i < RD_LAT; i++) begin
                bar_q[i] <= bar_q[i-1];
            end
        end
    end

    assign src_pix = test_mode ? bar_q[RD_LAT-1] : pixel_data;
`else
    assign src_pix = pixel_data;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pixel <= '0;
        end else begin
            pixel <= de_q[DEPTH-2] ? src_pix : '0;
        end
    end

    // ------------------------------------------------------------------
    // Vblank interrupt: registered so it is low exactly while the
    // counters sit at (0, V_ACTIVE); not routed through the delay line.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            v_blank_interupt <= 1'b1;
        end else begin
            v_blank_interupt <= !(h_last && (v_cnt == V_LAST_ACT));
        end
    end

    assign de     = de_q[DEPTH-1];
    assign h_sync = hs_q[DEPTH-1] ? SYNC_POL : ~SYNC_POL;
    assign v_sync = vs_q[DEPTH-1] ? SYNC_POL : ~SYNC_POL;

endmodule
